tlc_phase_scheduler: RTL and testbench
======================================

TLC_PHASE_SCHEDULER -- requirements
Module: tlc_phase_scheduler

Interface
REQ-001 Parameter AMBER_CYCLES, default 4: cycles an amber phase lasts before timer_done asserts.
REQ-002 Parameter MIN_GREEN_CYCLES, default 8: minimum cycles of any green phase before a change is requested or released.
REQ-003 Parameter MAX_GREEN_CYCLES, default 32: road-B green ceiling, used only under TLC_MAX_GREEN_EN.
REQ-004 Parameter CNT_W, default 8: phase counter width; every cycle parameter SHALL be in 1..2^CNT_W-1.
REQ-005 clk  in  1  single clock; all state updates on posedge clk.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 lamp_code  in  7  lamp output fed back from the light controller.
REQ-008 sensor_b  in  1  raw road-B vehicle sensor, level.
REQ-009 ped_req  in  1  pedestrian crossing request, single-cycle pulse or level.
REQ-010 timer_done  out  1  amber expiry to the light controller.
REQ-011 traffic_b  out  1  qualified road-B service request to the light controller.
REQ-012 phase  out  3  registered decoded phase: 0 A_GREEN, 1 A_AMBER, 2 B_GREEN, 3 B_AMBER, 4 FAULT.
REQ-013 fault  out  1  high while phase is FAULT.

Function
REQ-014 Decode SHALL be exact-match: 0001100 A_GREEN, 1001010 A_AMBER, 0100001 B_GREEN, 1010001 B_AMBER, any other code FAULT.
REQ-015 phase register SHALL load the decoded phase every cycle, giving one cycle of latency.
REQ-016 When the decoded phase differs from the registered phase, cnt SHALL load 0; otherwise it SHALL increment, saturating at 2^CNT_W-1.
REQ-017 timer_done SHALL be 1 iff phase is A_AMBER or B_AMBER and cnt >= AMBER_CYCLES-1; it is a level held until the phase changes.
REQ-018 req_latch SHALL set on (sensor_b | ped_req) in any phase other than B_GREEN, and SHALL clear while phase is B_GREEN; clear wins.
REQ-019 In A_GREEN, traffic_b = req_latch && cnt >= MIN_GREEN_CYCLES-1.
REQ-020 In A_AMBER, traffic_b SHALL be 1, so that the first controller B-green cycle is held before phase updates.
REQ-021 In B_GREEN, traffic_b = (cnt < MIN_GREEN_CYCLES-1) || sensor_b, subject to REQ-029.
REQ-022 In B_AMBER and FAULT, traffic_b SHALL be 0.
REQ-023 In FAULT, timer_done SHALL be 0 and fault SHALL be 1; recovery is automatic when a valid code is decoded, with cnt reloaded to 0.
REQ-024 All outputs SHALL be combinational from registered state and sensor_b only, with no lamp_code-to-output combinational path.
REQ-025 A lamp code change mid-count (e.g. a controller reset) SHALL restart cnt with no stale timer_done beyond one cycle.

Reset
REQ-026 On rst=1 at a clock edge: phase=A_GREEN, cnt=0, req_latch=0.
REQ-027 Outputs during and after reset: timer_done=0, traffic_b=0, fault=0, phase=0.
REQ-028 Reset SHALL take priority over all other updates, including during an amber count.

Configuration
REQ-029 With TLC_MAX_GREEN_EN defined, traffic_b in B_GREEN SHALL be forced to 0 once cnt >= MAX_GREEN_CYCLES-1, regardless of sensor_b.
REQ-030 Without TLC_MAX_GREEN_EN, MAX_GREEN_CYCLES SHALL be unused and B_GREEN can be held indefinitely by sensor_b.

Structure
REQ-031 Package tlc_pkg SHALL hold the phase enum (3-bit) and the four lamp-code localparams, shared with the light controller.
REQ-032 A sub-module tlc_lamp_decode (lamp_code -> phase, purely combinational) SHALL perform REQ-014.

Verification
REQ-033 The bench SHALL cover at least these directed scenarios:
- Reset with lamp_code=0001100, sensor_b=0 -> phase=0, traffic_b=0, timer_done=0 for all cycles.
- ped_req 1-cycle pulse at cnt=2 in A_GREEN (MIN=8) -> traffic_b rises when cnt=7 and stays high until phase=A_AMBER ends.
- lamp_code steps to 1001010 (AMBER=4) -> timer_done=0 for 4 cycles after the change, then 1 until the code changes.
- B_GREEN with sensor_b held 1 -> traffic_b stays 1; with TLC_MAX_GREEN_EN and MAX=32, traffic_b drops when cnt=31.
- lamp_code=1111111 for 3 cycles -> fault=1, traffic_b=0, timer_done=0; return to 0001100 -> fault=0, cnt=0.
- rst asserted mid B_AMBER at cnt=2 -> next cycle phase=0, cnt=0, req_latch=0, timer_done=0.

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared phase encoding and lamp codes for the traffic-light controller and its phase scheduler.
package tlc_pkg;

  typedef enum logic [2:0] {
    PH_A_GREEN = 3'd0,
    PH_A_AMBER = 3'd1,
    PH_B_GREEN = 3'd2,
    PH_B_AMBER = 3'd3,
    PH_FAULT   = 3'd4
  } phase_e;

  localparam logic [6:0] LAMP_A_GREEN = 7'b0001100;
  localparam logic [6:0] LAMP_A_AMBER = 7'b1001010;
  localparam logic [6:0] LAMP_B_GREEN = 7'b0100001;
  localparam logic [6:0] LAMP_B_AMBER = 7'b1010001;

  function automatic logic is_amber(input phase_e p);
    return (p == PH_A_AMBER) || (p == PH_B_AMBER);
  endfunction

endpackage

// File: rtl/tlc_lamp_decode.sv
// Combinational exact-match decode of the 7-bit lamp feedback into a phase; any unknown code is FAULT.
module tlc_lamp_decode
  import tlc_pkg::*;
(
  input  logic [6:0] lamp_code,
  output phase_e     phase
);

  always_comb begin
    case (lamp_code)
      LAMP_A_GREEN: phase = PH_A_GREEN;
      LAMP_A_AMBER: phase = PH_A_AMBER;
      LAMP_B_GREEN: phase = PH_B_GREEN;
      LAMP_B_AMBER: phase = PH_B_AMBER;
      default:      phase = PH_FAULT;
    endcase
  end

endmodule

// File: rtl/tlc_phase_scheduler.sv
// Tracks the controller's current phase from lamp feedback, times amber and gates road-B requests.
// Optional build macro TLC_MAX_GREEN_EN caps road-B green at MAX_GREEN_CYCLES.
module tlc_phase_scheduler
  import tlc_pkg::*;
#(
  parameter int AMBER_CYCLES     = 4,
  parameter int MIN_GREEN_CYCLES = 8,
  parameter int MAX_GREEN_CYCLES = 32,
  parameter int CNT_W            = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] lamp_code,
  input  logic       sensor_b,
  input  logic       ped_req,
  output logic       timer_done,
  output logic       traffic_b,
  output logic [2:0] phase,
  output logic       fault
);

  localparam logic [CNT_W-1:0] AMBER_LAST = CNT_W'(AMBER_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIN_LAST   = CNT_W'(MIN_GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  phase_e           dec_phase;
  phase_e           phase_d, phase_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             req_latch_d, req_latch_q;

  tlc_lamp_decode u_decode (
    .lamp_code (lamp_code),
    .phase     (dec_phase)
  );

  // cnt counts cycles spent in the registered phase; it restarts on the same edge the phase changes.
  always_comb begin
    phase_d     = dec_phase;
    cnt_d       = cnt_q;
    req_latch_d = req_latch_q;
    if (dec_phase != phase_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (phase_q == PH_B_GREEN) begin
      req_latch_d = 1'b0;
    end else begin
      req_latch_d = req_latch_q | sensor_b | ped_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q     <= PH_A_GREEN;
      cnt_q       <= '0;
      req_latch_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      req_latch_q <= req_latch_d;
    end
  end

`ifdef TLC_MAX_GREEN_EN
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_GREEN_CYCLES - 1);
  logic max_green_hit;
  assign max_green_hit = (cnt_q >= MAX_LAST);
`else
  logic max_green_hit;
  logic unused_max_green;
  assign max_green_hit    = 1'b0;
  assign unused_max_green = ^MAX_GREEN_CYCLES;
`endif

  // Outputs see only registered state plus the live road-B sensor, never lamp_code directly.
  always_comb begin
    timer_done = 1'b0;
    traffic_b  = 1'b0;
    case (phase_q)
      PH_A_GREEN: traffic_b = req_latch_q && (cnt_q >= MIN_LAST);
      PH_A_AMBER: traffic_b = 1'b1;
      PH_B_GREEN: traffic_b = ((cnt_q < MIN_LAST) || sensor_b) && !max_green_hit;
      default:    traffic_b = 1'b0;
    endcase
    if (is_amber(phase_q) && (cnt_q >= AMBER_LAST)) begin
      timer_done = 1'b1;
    end
  end

  assign phase = phase_q;
  assign fault = (phase_q == PH_FAULT);

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Randomized and directed bench for tlc_phase_scheduler against a cycle-level behavioural model.
module tb_tlc_phase_scheduler;

  localparam int AMBER = 4;
  localparam int MIN_G = 8;
  localparam int MAX_G = 32;
  localparam int CNT_W = 8;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic       clk;
  logic       rst;
  logic [6:0] lamp_code;
  logic       sensor_b;
  logic       ped_req;
  logic       timer_done;
  logic       traffic_b;
  logic [2:0] phase;
  logic       fault;

  int checks;
  int failures;

  // model state: phase as it appears after the one-cycle register, cycles spent in it, pending request
  int m_phase;
  int m_cnt;
  bit m_latch;

  tlc_phase_scheduler #(
    .AMBER_CYCLES     (AMBER),
    .MIN_GREEN_CYCLES (MIN_G),
    .MAX_GREEN_CYCLES (MAX_G),
    .CNT_W            (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .lamp_code  (lamp_code),
    .sensor_b   (sensor_b),
    .ped_req    (ped_req),
    .timer_done (timer_done),
    .traffic_b  (traffic_b),
    .phase      (phase),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int decode_code(input logic [6:0] c);
    logic [6:0] table_codes [4];
    table_codes = '{7'b0001100, 7'b1001010, 7'b0100001, 7'b1010001};
    for (int k = 0; k < 4; k++) if (c === table_codes[k]) return k;
    return 4;
  endfunction

  function automatic bit exp_done();
    return (m_phase == 1 || m_phase == 3) && (m_cnt >= AMBER - 1);
  endfunction

  function automatic bit exp_traffic();
    bit t;
    case (m_phase)
      0: t = m_latch && (m_cnt >= MIN_G - 1);
      1: t = 1'b1;
      2: begin
        t = (m_cnt < MIN_G - 1) || (sensor_b === 1'b1);
`ifdef TLC_MAX_GREEN_EN
        if (m_cnt >= MAX_G - 1) t = 1'b0;
`endif
      end
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  // One clock edge: advance the model with the inputs present at the edge, then settle.
  task automatic tick();
    int d;
    @(posedge clk);
    if (rst) begin
      m_phase = 0;
      m_cnt   = 0;
      m_latch = 1'b0;
    end else begin
      d = decode_code(lamp_code);
      if (m_phase == 2) m_latch = 1'b0;
      else m_latch = m_latch | sensor_b | ped_req;
      if (d != m_phase) m_cnt = 0;
      else if (m_cnt < CNT_SAT) m_cnt = m_cnt + 1;
      m_phase = d;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; lamp_code = 7'b0001100; sensor_b = 1'b0; ped_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) rst = 1'b0;
      tick();
      checks++;
      if (phase !== 3'd0 || traffic_b !== 1'b0 || timer_done !== 1'b0 || fault !== 1'b0) begin
        failures++;
        $display("FAIL reset_outputs cyc=%0d got phase=%0d tb=%b td=%b f=%b required 0/0/0/0",
                 i, phase, traffic_b, timer_done, fault);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_ped_request();
    rst = 1'b1; tick(); rst = 1'b0;
    tick(); tick();
    checks++;
    if (dut.cnt_q !== CNT_W'(2)) begin
      failures++;
      $display("FAIL ped_cnt_start got=%0d required=2", dut.cnt_q);
    end
    ped_req = 1'b1; tick(); ped_req = 1'b0;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (traffic_b !== (m_cnt >= MIN_G - 1) || traffic_b !== exp_traffic()) begin
        failures++;
        $display("FAIL ped_traffic cnt=%0d got=%b required=%b", m_cnt, traffic_b, (m_cnt >= MIN_G - 1));
      end
      tick();
    end
    $display("test_ped_request done");
  endtask

  task automatic test_amber_timer();
    lamp_code = 7'b1001010;
    for (int i = 0; i < 8; i++) begin
      tick();
      // the cycle before this edge still showed A_GREEN, so 4 low cycles span the change
      checks++;
      if (timer_done !== (i >= AMBER - 1) || traffic_b !== 1'b1 || phase !== 3'd1) begin
        failures++;
        $display("FAIL amber_timer i=%0d got td=%b tb=%b ph=%0d required td=%b tb=1 ph=1",
                 i, timer_done, traffic_b, phase, (i >= AMBER - 1));
      end
    end
    $display("test_amber_timer done");
  endtask

  task automatic test_b_green_hold();
    bit req;
    lamp_code = 7'b0100001; sensor_b = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
`ifdef TLC_MAX_GREEN_EN
      req = (i < MAX_G - 1);
`else
      req = 1'b1;
`endif
      checks++;
      if (traffic_b !== req || phase !== 3'd2 || timer_done !== 1'b0) begin
        failures++;
        $display("FAIL bgreen_hold cnt=%0d got tb=%b ph=%0d td=%b required tb=%b ph=2 td=0",
                 i, traffic_b, phase, timer_done, req);
      end
    end
    sensor_b = 1'b0; #1;
    checks++;
    if (traffic_b !== 1'b0) begin
      failures++;
      $display("FAIL bgreen_release got=%b required=0", traffic_b);
    end
    lamp_code = 7'b1010001;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (traffic_b !== 1'b0 || timer_done !== (i >= AMBER - 1) || phase !== 3'd3) begin
        failures++;
        $display("FAIL bamber i=%0d got tb=%b td=%b ph=%0d required tb=0 td=%b ph=3",
                 i, traffic_b, timer_done, phase, (i >= AMBER - 1));
      end
    end
    $display("test_b_green_hold done");
  endtask

  task automatic test_fault();
    lamp_code = 7'b1111111; sensor_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (fault !== 1'b1 || traffic_b !== 1'b0 || timer_done !== 1'b0 || phase !== 3'd4) begin
        failures++;
        $display("FAIL fault_hold i=%0d got f=%b tb=%b td=%b ph=%0d required 1/0/0/4",
                 i, fault, traffic_b, timer_done, phase);
      end
    end
    lamp_code = 7'b0001100; sensor_b = 1'b0;
    tick();
    checks++;
    if (fault !== 1'b0 || phase !== 3'd0 || dut.cnt_q !== '0) begin
      failures++;
      $display("FAIL fault_recover got f=%b ph=%0d cnt=%0d required f=0 ph=0 cnt=0",
               fault, phase, dut.cnt_q);
    end
    $display("test_fault done");
  endtask

  task automatic test_reset_mid_amber();
    lamp_code = 7'b1010001; sensor_b = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (phase !== 3'd3 || dut.cnt_q !== CNT_W'(2)) begin
      failures++;
      $display("FAIL rst_amber_setup got ph=%0d cnt=%0d required ph=3 cnt=2", phase, dut.cnt_q);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (phase !== 3'd0 || dut.cnt_q !== '0 || dut.req_latch_q !== 1'b0 || timer_done !== 1'b0) begin
      failures++;
      $display("FAIL rst_amber got ph=%0d cnt=%0d latch=%b td=%b required 0/0/0/0",
               phase, dut.cnt_q, dut.req_latch_q, timer_done);
    end
    rst = 1'b0; sensor_b = 1'b0; lamp_code = 7'b0001100;
    tick();
    $display("test_reset_mid_amber done");
  endtask

  task automatic test_saturation();
    rst = 1'b1; tick(); rst = 1'b0;
    ped_req = 1'b1; tick(); ped_req = 1'b0;
    for (int i = 0; i < 300; i++) tick();
    checks++;
    if (traffic_b !== 1'b1 || dut.cnt_q !== CNT_W'(CNT_SAT)) begin
      failures++;
      $display("FAIL cnt_saturate got tb=%b cnt=%0d required tb=1 cnt=%0d", traffic_b, dut.cnt_q, CNT_SAT);
    end
    $display("test_saturation done");
  endtask

  task automatic test_random();
    int hold;
    int sel;
    int bad;
    hold = 0; bad = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        sel  = int'($urandom_range(0, 9));
        case (sel)
          0, 1, 2: lamp_code = 7'b0001100;
          3:       lamp_code = 7'b1001010;
          4, 5:    lamp_code = 7'b0100001;
          6:       lamp_code = 7'b1010001;
          default: lamp_code = 7'($urandom);
        endcase
        hold = int'($urandom_range(1, 45));
      end
      hold--;
      sensor_b = ($urandom_range(0, 2) == 0);
      ped_req  = ($urandom_range(0, 15) == 0);
      rst      = ($urandom_range(0, 199) == 0);
      #1;
      checks++;
      if (phase !== 3'(m_phase) || timer_done !== exp_done() || traffic_b !== exp_traffic() ||
          fault !== (m_phase == 4)) begin
        failures++;
        bad++;
        if (bad < 10)
          $display("FAIL random cyc=%0d got ph=%0d td=%b tb=%b f=%b required ph=%0d td=%b tb=%b f=%b",
                   i, phase, timer_done, traffic_b, fault, m_phase, exp_done(), exp_traffic(), (m_phase == 4));
      end
      tick();
    end
    rst = 1'b0; sensor_b = 1'b0; ped_req = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    checks = 0; failures = 0;
    m_phase = 0; m_cnt = 0; m_latch = 1'b0;
    rst = 1'b1; lamp_code = 7'b0001100; sensor_b = 1'b0; ped_req = 1'b0;
    test_reset();
    test_ped_request();
    test_amber_timer();
    test_b_green_hold();
    test_fault();
    test_reset_mid_amber();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
